// File: rtl/uart_wb_burst_bridge_pkg.sv
// Shared types and constants for the UART byte-stream to Wishbone burst bridge.
package uart_wb_burst_bridge_pkg;

  typedef enum logic [1:0] {
    OP_WR  = 2'b00,
    OP_RD  = 2'b01,
    OP_IRQ = 2'b10,
    OP_RST = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WDATA,
    ST_WB,
    ST_RDATA,
    ST_DRAIN,
    ST_STAT
  } state_e;

  localparam logic [7:0] STAT_OK      = 8'hA5;
  localparam logic [7:0] STAT_TIMEOUT = 8'hEE;

endpackage

// File: rtl/uart_wb_burst_bridge_wb_timeout_ctr.sv
// Wishbone ack watchdog: counts while start is held, saturates at TIMEOUT_CYCLES.
module wb_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_q, count_d;

  assign expired = (count_q == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (start && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_wb_burst_bridge.sv
// Byte-stream command bridge: parses UART bytes into Wishbone single/burst
// accesses and returns read data plus one status byte per command.
module uart_wb_burst_bridge
  import uart_wb_burst_bridge_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int BURST_MAX      = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ADDR_STEP      = DATA_W / 8
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [7:0]        S_axis_tdata,
  input  logic              S_axis_tvalid,
  output logic              S_axis_tready,
  output logic [7:0]        M_axis_tdata,
  output logic              M_axis_tvalid,
  input  logic              M_axis_tready,
  output logic [ADDR_W-1:0] Addr,
  output logic [DATA_W-1:0] Wdata,
  output logic              We,
  output logic              Cs,
  input  logic [DATA_W-1:0] Rdata,
  input  logic              Ack,
  output logic              Irq,
  output logic              Rst_req
);

  localparam logic [1:0]        ADDR_LAST = 2'(ADDR_W / 8 - 1);
  localparam logic [1:0]        DATA_LAST = 2'(DATA_W / 8 - 1);
  localparam logic [3:0]        BEATS_MAX = 4'(BURST_MAX - 1);
  localparam logic [ADDR_W-1:0] ADDR_INC  = ADDR_W'(ADDR_STEP);

  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [3:0]        beats_q, beats_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [7:0]        status_q, status_d;
  logic              irq_q, irq_d;
  logic              rst_req_q, rst_req_d;
  logic              tready_q, tready_d;
  logic              s_fire;
  logic              timeout_expired;

  assign s_fire        = S_axis_tvalid && tready_q;
  assign S_axis_tready = tready_q;
  assign Cs            = (state_q == ST_WB);
  assign We            = Cs && (op_q == OP_WR);
  assign Addr          = addr_q;
  assign Wdata         = wdata_q;
  assign Irq           = irq_q;
  assign Rst_req       = rst_req_q;
  assign M_axis_tvalid = (state_q == ST_RDATA) || (state_q == ST_STAT);
  assign M_axis_tdata  = (state_q == ST_RDATA) ? rdata_q[DATA_W-1 -: 8] :
                         (state_q == ST_STAT)  ? status_q : 8'h00;

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (Clk),
    .rst    (Rst),
    .start  (state_q == ST_WB),
    .clear  (state_q != ST_WB),
    .expired(timeout_expired)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    beats_d    = beats_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    status_d   = status_q;
    irq_d      = 1'b0;
    rst_req_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: if (s_fire) begin
        op_d       = op_e'(S_axis_tdata[7:6]);
        beats_d    = (S_axis_tdata[3:0] > BEATS_MAX) ? BEATS_MAX : S_axis_tdata[3:0];
        byte_cnt_d = '0;
        status_d   = STAT_OK;
        case (op_e'(S_axis_tdata[7:6]))
          OP_IRQ:  begin irq_d = 1'b1;     state_d = ST_STAT; end
          OP_RST:  begin rst_req_d = 1'b1; state_d = ST_STAT; end
          default: state_d = ST_ADDR;
        endcase
      end
      ST_ADDR: if (s_fire) begin
        addr_d = ADDR_W'({addr_q, S_axis_tdata});
        if (byte_cnt_q == ADDR_LAST) begin
          byte_cnt_d = '0;
          state_d    = (op_q == OP_WR) ? ST_WDATA : ST_WB;
        end else begin
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      ST_WDATA: if (s_fire) begin
        wdata_d = DATA_W'({wdata_q, S_axis_tdata});
        if (byte_cnt_q == DATA_LAST) begin
          byte_cnt_d = '0;
          state_d    = ST_WB;
        end else begin
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      // Ack has priority over a timeout that expires in the same cycle
      ST_WB: if (Ack) begin
        byte_cnt_d = '0;
        if (op_q == OP_RD) begin
          rdata_d = Rdata;
          state_d = ST_RDATA;
        end else if (beats_q != 4'd0) begin
          beats_d = beats_q - 4'd1;
          addr_d  = addr_q + ADDR_INC;
          state_d = ST_WDATA;
        end else begin
          state_d = ST_STAT;
        end
      end else if (timeout_expired) begin
        byte_cnt_d = '0;
        status_d   = STAT_TIMEOUT;
        state_d    = (op_q == OP_WR && beats_q != 4'd0) ? ST_DRAIN : ST_STAT;
      end
      ST_RDATA: if (M_axis_tready) begin
        rdata_d = rdata_q << 8;
        if (byte_cnt_q == DATA_LAST) begin
          byte_cnt_d = '0;
          if (beats_q != 4'd0) begin
            beats_d = beats_q - 4'd1;
            addr_d  = addr_q + ADDR_INC;
            state_d = ST_WB;
          end else begin
            state_d = ST_STAT;
          end
        end else begin
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      // beats_q counts the whole beats of the aborted burst still to be swallowed
      ST_DRAIN: if (s_fire) begin
        if (byte_cnt_q == DATA_LAST) begin
          byte_cnt_d = '0;
          beats_d    = beats_q - 4'd1;
          if (beats_q == 4'd1) begin
            state_d = ST_STAT;
          end
        end else begin
          byte_cnt_d = byte_cnt_q + 2'd1;
        end
      end
      ST_STAT: if (M_axis_tready) begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    tready_d = (state_d == ST_IDLE) || (state_d == ST_ADDR) ||
               (state_d == ST_WDATA) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_WR;
      beats_q    <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      status_q   <= '0;
      irq_q      <= 1'b0;
      rst_req_q  <= 1'b0;
      tready_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      beats_q    <= beats_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      status_q   <= status_d;
      irq_q      <= irq_d;
      rst_req_q  <= rst_req_d;
      tready_q   <= tready_d;
    end
  end

endmodule

// File: tb/tb_uart_wb_burst_bridge.sv
// Self-checking bench for uart_wb_burst_bridge: directed and randomized commands
// compared against a transaction-level model of the bridge.
module tb_uart_wb_burst_bridge;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int BURST_MAX  = 8;
  localparam int TIMEOUT    = 1024;
  localparam int WAIT_LIMIT = 20000;

  logic              Clk;
  logic              Rst;
  logic [7:0]        S_axis_tdata;
  logic              S_axis_tvalid;
  logic              S_axis_tready;
  logic [7:0]        M_axis_tdata;
  logic              M_axis_tvalid;
  logic              M_axis_tready;
  logic [ADDR_W-1:0] Addr;
  logic [DATA_W-1:0] Wdata;
  logic              We;
  logic              Cs;
  logic [DATA_W-1:0] Rdata;
  logic              Ack;
  logic              Irq;
  logic              Rst_req;

  uart_wb_burst_bridge #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .BURST_MAX(BURST_MAX),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .S_axis_tdata(S_axis_tdata),
    .S_axis_tvalid(S_axis_tvalid),
    .S_axis_tready(S_axis_tready),
    .M_axis_tdata(M_axis_tdata),
    .M_axis_tvalid(M_axis_tvalid),
    .M_axis_tready(M_axis_tready),
    .Addr(Addr),
    .Wdata(Wdata),
    .We(We),
    .Cs(Cs),
    .Rdata(Rdata),
    .Ack(Ack),
    .Irq(Irq),
    .Rst_req(Rst_req)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  // Observed traffic, filled by the monitors below
  logic [7:0]  txQ[$];
  logic [31:0] obsAddr[$];
  logic [31:0] obsWdata[$];
  logic        obsWe[$];
  int          obsLen[$];
  int          irqCount    = 0;
  int          rstReqCount = 0;
  int          stabViol    = 0;
  int          treadyViol  = 0;

  // Slave behaviour per Wishbone access: Ack lands in the Nth Cs-high cycle (0 = never)
  int          ackQ[$];
  logic [31:0] rdQ[$];
  int          holdAt  = -1;
  int          holdCnt = 0;

  // Per-command stimulus: ack delay, write data and read data for each beat
  int          curAck[$];
  logic [31:0] curWd[$];
  logic [31:0] curRd[$];

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wishbone slave and Cs/Irq monitor
  initial begin
    int csCount;
    int curD;
    logic [31:0] capA, capWd;
    logic capWe;
    csCount = 0;
    curD = 0;
    capA = '0;
    capWd = '0;
    capWe = 1'b0;
    Ack = 1'b0;
    Rdata = '0;
    forever begin
      @(negedge Clk);
      if (Irq) irqCount++;
      if (Rst_req) rstReqCount++;
      if (Rst) begin
        csCount = 0;
        Ack = 1'b0;
      end else if (Cs) begin
        if (csCount == 0) begin
          capA = Addr;
          capWe = We;
          capWd = Wdata;
          curD = (ackQ.size() > 0) ? ackQ.pop_front() : 1;
          if (!We) Rdata = (rdQ.size() > 0) ? rdQ.pop_front() : $urandom();
        end
        csCount++;
        Ack = (csCount == curD);
        if (S_axis_tready) treadyViol++;
      end else begin
        if (csCount > 0) begin
          obsAddr.push_back(capA);
          obsWe.push_back(capWe);
          obsWdata.push_back(capWd);
          obsLen.push_back(csCount);
        end
        csCount = 0;
        Ack = 1'b0;
      end
    end
  end

  // Response-side sink with random and forced backpressure
  initial begin
    logic prevValid, prevReady;
    logic [7:0] prevData;
    prevValid = 1'b0;
    prevReady = 1'b0;
    prevData = '0;
    M_axis_tready = 1'b0;
    forever begin
      @(negedge Clk);
      if (Rst) begin
        prevValid = 1'b0;
        prevReady = 1'b0;
        M_axis_tready = 1'b0;
      end else begin
        if (prevValid && prevReady) txQ.push_back(prevData);
        if (prevValid && !prevReady && (M_axis_tvalid !== 1'b1 || M_axis_tdata !== prevData))
          stabViol++;
        if (holdCnt > 0) begin
          M_axis_tready = 1'b0;
          holdCnt--;
        end else if (holdAt >= 0 && txQ.size() == holdAt) begin
          M_axis_tready = 1'b0;
          holdCnt = 49;
          holdAt = -1;
        end else begin
          M_axis_tready = ($urandom_range(0, 3) != 0);
        end
        prevValid = M_axis_tvalid;
        prevReady = M_axis_tready;
        prevData = M_axis_tdata;
      end
    end
  end

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge Clk);
    S_axis_tdata = b;
    S_axis_tvalid = 1'b1;
    while (S_axis_tready !== 1'b1 && n < WAIT_LIMIT) begin
      @(negedge Clk);
      n++;
    end
    if (n >= WAIT_LIMIT) checkOutput("send_bound", 64'(n), 64'(WAIT_LIMIT - 1));
    @(posedge Clk);
    #1;
    S_axis_tvalid = 1'b0;
  endtask

  task automatic fillRandom();
    curAck.delete();
    curWd.delete();
    curRd.delete();
    for (int i = 0; i < BURST_MAX; i++) begin
      curAck.push_back(($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 4)));
      curWd.push_back($urandom());
      curRd.push_back($urandom());
    end
  endtask

  // Model: a burst is a list of beats at addr + 4*i; a beat whose ack never comes
  // within the entry cycle plus TIMEOUT counted cycles ends the command with 0xEE.
  task automatic applyStimulus(input logic [1:0] op, input logic [3:0] field, input logic [31:0] addr);
    int beats, n, irq0, rst0;
    bit aborted;
    logic [7:0]  expTx[$];
    logic [31:0] eA[$];
    logic [31:0] eWd[$];
    logic        eWe[$];
    int          eLen[$];

    beats = ((int'(field) > BURST_MAX - 1) ? BURST_MAX - 1 : int'(field)) + 1;
    aborted = 1'b0;
    if (op[1]) begin
      expTx.push_back(8'hA5);
    end else begin
      for (int i = 0; i < beats && !aborted; i++) begin
        eA.push_back(addr + 32'(i * 4));
        eWe.push_back(op == 2'b00);
        eWd.push_back(curWd[i]);
        if (curAck[i] == 0 || curAck[i] > TIMEOUT + 1) begin
          eLen.push_back(TIMEOUT + 1);
          expTx.push_back(8'hEE);
          aborted = 1'b1;
        end else begin
          eLen.push_back(curAck[i]);
          if (op == 2'b01)
            for (int k = 3; k >= 0; k--) expTx.push_back(curRd[i][8*k +: 8]);
        end
      end
      if (!aborted) expTx.push_back(8'hA5);
    end

    ackQ = curAck;
    rdQ = curRd;
    txQ.delete();
    obsAddr.delete();
    obsWe.delete();
    obsWdata.delete();
    obsLen.delete();
    irq0 = irqCount;
    rst0 = rstReqCount;

    sendByte({op, 2'($urandom()), field});
    if (!op[1]) begin
      for (int k = 3; k >= 0; k--) sendByte(addr[8*k +: 8]);
      if (op == 2'b00)
        for (int i = 0; i < beats; i++)
          for (int k = 3; k >= 0; k--) sendByte(curWd[i][8*k +: 8]);
    end

    n = 0;
    while (txQ.size() < expTx.size() && n < WAIT_LIMIT) begin
      @(negedge Clk);
      n++;
    end
    if (n >= WAIT_LIMIT) checkOutput("response_bound", 64'(txQ.size()), 64'(expTx.size()));
    repeat (4) @(negedge Clk);

    checkOutput("tx_count", 64'(txQ.size()), 64'(expTx.size()));
    for (int i = 0; i < expTx.size() && i < txQ.size(); i++)
      checkOutput($sformatf("tx_byte[%0d]", i), 64'(txQ[i]), 64'(expTx[i]));
    checkOutput("wb_count", 64'(obsAddr.size()), 64'(eA.size()));
    for (int i = 0; i < eA.size() && i < obsAddr.size(); i++) begin
      checkOutput($sformatf("wb_addr[%0d]", i), 64'(obsAddr[i]), 64'(eA[i]));
      checkOutput($sformatf("wb_we[%0d]", i), 64'(obsWe[i]), 64'(eWe[i]));
      checkOutput($sformatf("wb_cs_len[%0d]", i), 64'(obsLen[i]), 64'(eLen[i]));
      if (eWe[i]) checkOutput($sformatf("wb_wdata[%0d]", i), 64'(obsWdata[i]), 64'(eWd[i]));
    end
    checkOutput("irq_pulses", 64'(irqCount - irq0), 64'(op == 2'b10));
    checkOutput("rst_req_pulses", 64'(rstReqCount - rst0), 64'(op == 2'b11));
  endtask

  initial begin
    int n;
    Rst = 1'b1;
    S_axis_tvalid = 1'b0;
    S_axis_tdata = 8'h00;
    #1;
    checkOutput("reset_ctrl", 64'({S_axis_tready, M_axis_tvalid, M_axis_tdata, Cs, We, Irq, Rst_req}), 64'd0);
    checkOutput("reset_bus", {Addr, Wdata}, 64'd0);
    repeat (3) @(negedge Clk);
    #2 Rst = 1'b0;

    $display("[TB] single write");
    curAck = {3};
    curWd = {32'hDEADBEEF};
    curRd = {};
    applyStimulus(2'b00, 4'h0, 32'h0000_0100);

    $display("[TB] read burst of 2 with a 50-cycle response stall");
    curAck = {2, 4};
    curRd = {32'h11223344, 32'h55667788};
    curWd = {};
    holdAt = 3;
    applyStimulus(2'b01, 4'h1, 32'h0000_0200);

    $display("[TB] write timeout then a normal read");
    curAck = {0};
    curWd = {$urandom()};
    applyStimulus(2'b00, 4'h0, $urandom() & 32'hFFFF_FFFC);
    curAck = {1, 2};
    curRd = {$urandom(), $urandom()};
    applyStimulus(2'b01, 4'h1, $urandom() & 32'hFFFF_FFFC);

    $display("[TB] burst write of 3 aborted on beat 2, tail drained");
    curAck = {2, 0, 1};
    curWd = {$urandom(), $urandom(), $urandom()};
    applyStimulus(2'b00, 4'h2, 32'h0000_0300);

    $display("[TB] ack in the same cycle as the timeout");
    curAck = {TIMEOUT + 1};
    curWd = {$urandom()};
    applyStimulus(2'b00, 4'h0, 32'h0000_0400);

    $display("[TB] irq and reset-request commands");
    applyStimulus(2'b10, 4'($urandom()), 32'h0);
    applyStimulus(2'b11, 4'($urandom()), 32'h0);

    $display("[TB] clipped bursts across the address wrap");
    fillRandom();
    for (int i = 0; i < BURST_MAX; i++) curAck[i] = 1;
    applyStimulus(2'b00, 4'hF, 32'hFFFF_FFF8);
    fillRandom();
    for (int i = 0; i < BURST_MAX; i++) curAck[i] = 2;
    applyStimulus(2'b01, 4'hF, 32'hFFFF_FFF0);

    $display("[TB] randomized commands");
    for (int r = 0; r < 12; r++) begin
      int sel;
      logic [1:0] op;
      fillRandom();
      sel = int'($urandom_range(0, 9));
      op = (sel < 4) ? 2'b00 : (sel < 8) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      applyStimulus(op, 4'($urandom_range(0, 15)),
                    ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : ($urandom() & 32'hFFFF_FFFC));
    end

    $display("[TB] reset in the middle of a read burst");
    fillRandom();
    for (int i = 0; i < BURST_MAX; i++) curAck[i] = 2;
    ackQ = curAck;
    rdQ = curRd;
    txQ.delete();
    sendByte(8'h43);
    for (int k = 0; k < 4; k++) sendByte(8'h10 + 8'(k));
    n = 0;
    while (txQ.size() < 5 && n < WAIT_LIMIT) begin
      @(negedge Clk);
      n++;
    end
    if (n >= WAIT_LIMIT) checkOutput("midburst_bound", 64'(txQ.size()), 64'd5);
    @(negedge Clk);
    #2 Rst = 1'b1;
    #1;
    checkOutput("midburst_reset_ctrl", 64'({S_axis_tready, M_axis_tvalid, M_axis_tdata, Cs, We, Irq, Rst_req}), 64'd0);
    checkOutput("midburst_reset_bus", {Addr, Wdata}, 64'd0);
    ackQ.delete();
    rdQ.delete();
    repeat (3) @(negedge Clk);
    #2 Rst = 1'b0;
    txQ.delete();
    obsAddr.delete();
    obsWe.delete();
    obsWdata.delete();
    obsLen.delete();
    repeat (40) @(negedge Clk);
    checkOutput("no_status_after_reset", 64'(txQ.size()), 64'd0);
    checkOutput("no_wb_after_reset", 64'(obsAddr.size()), 64'd0);

    $display("[TB] command after reset");
    fillRandom();
    curAck[0] = 2;
    applyStimulus(2'b00, 4'h0, 32'h0000_0500);

    checkOutput("m_axis_stable_under_backpressure", 64'(stabViol), 64'd0);
    checkOutput("s_axis_tready_low_during_wb", 64'(treadyViol), 64'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
